maint_event_logger: RTL

MAINT_EVENT_LOGGER -- requirements
Module: maint_event_logger

---
 rtl/maint_event_logger.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/maint_event_logger.sv
// rtl/maint_event_logger.sv - elevator maintenance event capture FIFO and two-byte log record writer
module maint_event_logger #(
    parameter int FIFO_DEPTH = 4,
    parameter int LOG_BYTES  = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       floor_arrive,
    input  logic       door_open,
    input  logic       overload,
    input  logic       fault,
    input  logic [3:0] floor,
    input  logic [3:0] fault_code,
    output logic [7:0] maint_data_out,
    output logic       data_enable,
    output logic       write_enable,
    output logic       log_full,
    output logic [7:0] drop_count
);

    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = PW + 1;
    localparam logic [11:0] LOG_LIMIT = 12'(LOG_BYTES);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    logic [5:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;

    state_t        state_q;
    logic [7:0]    data_q;
    logic          wen_q;
    logic [5:0]    seq_q;
    logic [11:0]   byte_cnt_q;
    logic          log_full_q;

    logic          any_evt, fifo_full, enq, deq, last_byte;
    logic [5:0]    evt_entry, head, next_head;
    logic [2:0]    n_evt, n_drop;
    logic [8:0]    drop_sum;

    always_comb begin
        evt_entry = 6'h00;
        if (fault)          evt_entry = {2'b11, fault_code};
        else if (overload)  evt_entry = {2'b10, floor};
        else if (door_open) evt_entry = {2'b01, floor};
        else                evt_entry = {2'b00, floor};

        n_evt     = 3'(fault) + 3'(overload) + 3'(door_open) + 3'(floor_arrive);
        any_evt   = (n_evt != 3'd0);
        fifo_full = (count_q == CW'(FIFO_DEPTH));
        enq       = any_evt && !fifo_full && !log_full_q;
        deq       = (state_q == PAY);
        n_drop    = n_evt - 3'(enq);
        drop_sum  = 9'(drop_q) + 9'(n_drop);
        drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];

        count_d = count_q;
        if (enq && !deq)      count_d = count_q + CW'(1);
        else if (!enq && deq) count_d = count_q - CW'(1);

        head      = fifo_q[rd_ptr_q];
        next_head = fifo_q[rd_ptr_q + PW'(1)];
        last_byte = (byte_cnt_q + 12'd1 == LOG_LIMIT);
    end

    // Entry storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (enq) fifo_q[wr_ptr_q] <= evt_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 8'h00;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Strobes and data are registered one state ahead, so the value seen in HDR/PAY is set on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            data_q     <= 8'h00;
            wen_q      <= 1'b0;
            seq_q      <= 6'd0;
            byte_cnt_q <= 12'd0;
            log_full_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0 && !log_full_q) begin
                        state_q <= HDR;
                        data_q  <= {head[5:4], seq_q};
                        wen_q   <= 1'b1;
                    end else begin
                        data_q  <= 8'h00;
                        wen_q   <= 1'b0;
                    end
                end
                HDR: begin
                    state_q    <= PAY;
                    data_q     <= {4'h0, head[3:0]};
                    wen_q      <= 1'b1;
                    byte_cnt_q <= byte_cnt_q + 12'd1;
                end
                PAY: begin
                    byte_cnt_q <= byte_cnt_q + 12'd1;
                    seq_q      <= seq_q + 6'd1;
                    if (last_byte) log_full_q <= 1'b1;
                    if (count_q > CW'(1) && !last_byte) begin
                        state_q <= HDR;
                        data_q  <= {next_head[5:4], seq_q + 6'd1};
                        wen_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        data_q  <= 8'h00;
                        wen_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    data_q  <= 8'h00;
                    wen_q   <= 1'b0;
                end
            endcase
        end
    end

    assign maint_data_out = data_q;
    assign data_enable    = wen_q;
    assign write_enable   = wen_q;
    assign log_full       = log_full_q;
    assign drop_count     = drop_q;

endmodule
